// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed seven-segment driver for N_DIGITS hex digits.
//   A prescaler produces one tick per digit slot; each tick advances the
//   digit index. Each slot opens with BLANK_CYCLES clocks of all-off output to
//   suppress ghosting, then drives the selected digit. The displayed value
//   lives in a shadow register that only changes at frame boundaries, so a
//   frame never shows a mix of old and new digits.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   value      : hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   load       : 1-cycle strobe, captures value into staging
//   digit_en   : per-digit enable (live)
//   dp         : per-digit decimal point enable (live)
//   lz_blank   : blank leading-zero digits (live)
//   anodes     : active-low digit selects (registered)
//   segments   : active-low segments, [6]=CA .. [0]=CG (registered)
//   dp_n       : active-low decimal point (registered)
//   frame_done : 1-cycle pulse after each frame boundary
module seg_scan_driver #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int N_DIGITS     = 8,
    parameter int BLANK_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    lz_blank,
    output logic [N_DIGITS-1:0]     anodes,
    output logic [6:0]              segments,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int DIV   = CLK_FREQ_HZ / DIGIT_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    logic [CNT_W-1:0]       count_reg;
    logic [IDX_W-1:0]       index_reg;
    logic [4*N_DIGITS-1:0]  staging_reg;
    logic [4*N_DIGITS-1:0]  shadow_reg;
    logic                   pending_reg;
    logic                   frame_done_reg;
    state_t                 state_reg, state_next;
    logic [BLK_W-1:0]       blank_cnt_reg, blank_cnt_next;
    logic [N_DIGITS-1:0]    anodes_reg, anodes_next;
    logic [6:0]             segments_reg, segments_next;
    logic                   dp_n_reg, dp_n_next;

    logic                   tick;
    logic                   boundary;
    logic [3:0]             nib [N_DIGITS];
    logic [N_DIGITS-1:0]    nib_nz;
    logic [N_DIGITS-1:0]    sel_onehot;
    logic [IDX_W-1:0]       msd_idx;
    logic                   lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001111;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign tick     = (count_reg == CNT_W'(DIV - 1));
    assign boundary = tick && (index_reg == IDX_W'(N_DIGITS - 1));

    // Per-digit views of the shadow value and the one-hot digit select.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nib[gi]        = shadow_reg[4*gi +: 4];
            assign nib_nz[gi]     = |shadow_reg[4*gi +: 4];
            assign sel_onehot[gi] = (index_reg == IDX_W'(gi));
        end
    endgenerate

    // Most significant non-zero digit; stays 0 for an all-zero value so
    // digit 0 always survives leading-zero blanking.
    always_comb begin
        msd_idx = '0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (nib_nz[i]) msd_idx = IDX_W'(i);
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            index_reg <= IDX_W'(N_DIGITS - 1);
        end else begin
            count_reg <= tick ? '0 : count_reg + 1'b1;
            if (tick) index_reg <= (index_reg == IDX_W'(N_DIGITS - 1)) ? '0 : index_reg + 1'b1;
        end
    end

    // Staging/shadow: a load on the boundary cycle bypasses staging so it
    // takes effect in the frame that starts right then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            staging_reg    <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= boundary;
            if (load) staging_reg <= value;
            if (boundary) begin
                if (pending_reg || load) shadow_reg <= load ? value : staging_reg;
                pending_reg <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    // Slot state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= BLANK;
            blank_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            blank_cnt_reg <= blank_cnt_next;
        end
    end

    // After reset the counter is 0 and the FSM idles in BLANK until the
    // first tick; a non-zero counter is a live anti-ghosting interval.
    always_comb begin
        state_next     = state_reg;
        blank_cnt_next = blank_cnt_reg;
        if (tick) begin
            if (BLANK_CYCLES == 0) begin
                state_next     = DRIVE;
                blank_cnt_next = '0;
            end else begin
                state_next     = BLANK;
                blank_cnt_next = BLK_W'(BLANK_CYCLES);
            end
        end else if (state_reg == BLANK && blank_cnt_reg != '0) begin
            blank_cnt_next = blank_cnt_reg - 1'b1;
            if (blank_cnt_reg == BLK_W'(1)) state_next = DRIVE;
        end
    end

    // Output decode; a single one-hot select keeps at most one anode low.
    assign lit = digit_en[index_reg] & ~(lz_blank & (index_reg > msd_idx));

    always_comb begin
        anodes_next   = '1;
        segments_next = 7'h7F;
        dp_n_next     = 1'b1;
        if (state_reg == DRIVE && lit) begin
            anodes_next   = ~sel_onehot;
            segments_next = hex7(nib[index_reg]);
            dp_n_next     = ~dp[index_reg];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anodes_reg   <= '1;
            segments_reg <= 7'h7F;
            dp_n_reg     <= 1'b1;
        end else begin
            anodes_reg   <= anodes_next;
            segments_reg <= segments_next;
            dp_n_reg     <= dp_n_next;
        end
    end

    assign anodes     = anodes_reg;
    assign segments   = segments_reg;
    assign dp_n       = dp_n_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed testbench for seg_scan_driver with DIV=10, N_DIGITS=4,
// BLANK_CYCLES=2. Cycle c is the state just after the c-th rising edge
// following reset release. Boundaries fall at c = 10 + 40m; digit k of a
// frame starting at b is lit for c = b+10k+3 .. b+10k+10.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  dp = 4'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        dp_n;
    logic        frame_done;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    seg_scan_driver #(
        .CLK_FREQ_HZ (1000),
        .DIGIT_HZ    (100),
        .N_DIGITS    (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .load      (load),
        .digit_en  (digit_en),
        .dp        (dp),
        .lz_blank  (lz_blank),
        .anodes    (anodes),
        .segments  (segments),
        .dp_n      (dp_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    function automatic int next_bnd(input int c);
        int b;
        b = 10;
        while (b <= c) b += 40;
        return b;
    endfunction

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        $display("load value=%h captured at cycle %0d", v, cyc);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({anodes, segments, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            $display("FAIL reset_outputs: got an=%b seg=%b dpn=%b fd=%b want 1111 1111111 1 0",
                     anodes, segments, dp_n, frame_done);
        end else n_pass++;
        repeat (3) @(posedge clk);
        release_reset();
        for (int c = 1; c <= 12; c++) begin
            step();
            n_total++;
            if (anodes !== 4'hF || segments !== 7'h7F) begin
                $display("FAIL startup_blank c=%0d: got an=%b seg=%b want 1111 1111111", cyc, anodes, segments);
            end else n_pass++;
            n_total++;
            if (frame_done !== (cyc == 10)) begin
                $display("FAIL startup_frame_done c=%0d: got %b want %b", cyc, frame_done, cyc == 10);
            end else n_pass++;
        end
        step();
        n_total++;
        if ({anodes, segments} !== {4'b1110, 7'b0000001}) begin
            $display("FAIL first_digit c=13: got an=%b seg=%b want 1110 0000001", anodes, segments);
        end else n_pass++;
        $display("reset scenario done at cycle %0d", cyc);
    endtask

    task automatic test_hex_digits();
        logic [6:0] seg_exp [4];
        int b, k, multi;
        seg_exp[0] = 7'b0111000;
        seg_exp[1] = 7'b0001000;
        seg_exp[2] = 7'b0010010;
        seg_exp[3] = 7'b1001111;
        digit_en = 4'hF; lz_blank = 1'b0; dp = 4'h0;
        run_to(14);
        pulse_load(16'h12AF);
        b = next_bnd(cyc);
        run_to(b - 5);
        n_total++;
        if ({anodes, segments} !== {4'b0111, 7'b0000001}) begin
            $display("FAIL pre_boundary_old c=%0d: got an=%b seg=%b want 0111 0000001", cyc, anodes, segments);
        end else n_pass++;
        multi = 0;
        for (int t = b + 1; t <= b + 40; t++) begin
            run_to(t);
            if ($countones(~anodes) > 1) multi++;
            if ((t - b) % 10 == 1 || (t - b) % 10 == 2) begin
                n_total++;
                if ({anodes, segments} !== {4'hF, 7'h7F}) begin
                    $display("FAIL slot_blank c=%0d: got an=%b seg=%b want 1111 1111111", cyc, anodes, segments);
                end else n_pass++;
            end
            if ((t - b) % 10 == 5) begin
                k = (t - b) / 10;
                n_total++;
                if ({anodes, segments} !== {~(4'b0001 << k), seg_exp[k]}) begin
                    $display("FAIL hex_digit%0d c=%0d: got an=%b seg=%b want %b %b",
                             k, cyc, anodes, segments, ~(4'b0001 << k), seg_exp[k]);
                end else n_pass++;
            end
        end
        n_total++;
        if (multi != 0) begin
            $display("FAIL one_anode: got %0d cycles with >1 anode low want 0", multi);
        end else n_pass++;
    endtask

    task automatic test_midframe_load();
        int b0, b1;
        lz_blank = 1'b1;
        b0 = next_bnd(cyc) - 40;
        run_to(b0 + 14);
        pulse_load(16'h00A0);
        run_to(b0 + 25);
        n_total++;
        if ({anodes, segments} !== {4'b1011, 7'b0010010}) begin
            $display("FAIL keep_old_d2 c=%0d: got an=%b seg=%b want 1011 0010010", cyc, anodes, segments);
        end else n_pass++;
        run_to(b0 + 35);
        n_total++;
        if ({anodes, segments} !== {4'b0111, 7'b1001111}) begin
            $display("FAIL keep_old_d3 c=%0d: got an=%b seg=%b want 0111 1001111", cyc, anodes, segments);
        end else n_pass++;
        b1 = b0 + 40;
        run_to(b1 - 1);
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL fd_early c=%0d: got %b want 0", cyc, frame_done);
        else n_pass++;
        run_to(b1);
        n_total++;
        if (frame_done !== 1'b1) $display("FAIL fd_boundary c=%0d: got %b want 1", cyc, frame_done);
        else n_pass++;
        run_to(b1 + 1);
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL fd_width c=%0d: got %b want 0", cyc, frame_done);
        else n_pass++;
        run_to(b1 + 5);
        n_total++;
        if ({anodes, segments} !== {4'b1110, 7'b0000001}) begin
            $display("FAIL new_d0 c=%0d: got an=%b seg=%b want 1110 0000001", cyc, anodes, segments);
        end else n_pass++;
        run_to(b1 + 15);
        n_total++;
        if ({anodes, segments} !== {4'b1101, 7'b0001000}) begin
            $display("FAIL new_d1 c=%0d: got an=%b seg=%b want 1101 0001000", cyc, anodes, segments);
        end else n_pass++;
        run_to(b1 + 25);
        n_total++;
        if ({anodes, segments} !== {4'hF, 7'h7F}) begin
            $display("FAIL lz_d2 c=%0d: got an=%b seg=%b want 1111 1111111", cyc, anodes, segments);
        end else n_pass++;
        run_to(b1 + 35);
        n_total++;
        if ({anodes, segments} !== {4'hF, 7'h7F}) begin
            $display("FAIL lz_d3 c=%0d: got an=%b seg=%b want 1111 1111111", cyc, anodes, segments);
        end else n_pass++;
    endtask

    task automatic test_zero_lz_dp();
        int bnd, dp_low, an0, other;
        dp = 4'b0001; lz_blank = 1'b1;
        pulse_load(16'h0000);
        bnd = next_bnd(cyc - 1);
        dp_low = 0; an0 = 0; other = 0;
        for (int t = bnd + 1; t <= bnd + 40; t++) begin
            run_to(t);
            if (dp_n === 1'b0) dp_low++;
            if (anodes === 4'b1110) an0++;
            else if (anodes !== 4'hF) other++;
            if (t == bnd + 2) begin
                n_total++;
                if (dp_n !== 1'b1) $display("FAIL dp_in_blank c=%0d: got %b want 1", cyc, dp_n);
                else n_pass++;
            end
            if (t == bnd + 3) begin
                n_total++;
                if ({anodes, segments, dp_n} !== {4'b1110, 7'b0000001, 1'b0}) begin
                    $display("FAIL zero_d0 c=%0d: got an=%b seg=%b dpn=%b want 1110 0000001 0",
                             cyc, anodes, segments, dp_n);
                end else n_pass++;
            end
            if (t == bnd + 15) begin
                n_total++;
                if (anodes !== 4'hF) $display("FAIL zero_d1_blank c=%0d: got %b want 1111", cyc, anodes);
                else n_pass++;
            end
        end
        n_total++;
        if (dp_low != 8) $display("FAIL dp_window: got %0d low cycles want 8", dp_low);
        else n_pass++;
        n_total++;
        if (an0 != 8 || other != 0) begin
            $display("FAIL zero_only_d0: got d0=%0d other=%0d want 8 0", an0, other);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nb;
        nb = next_bnd(cyc);
        run_to(nb - 1);
        pulse_load(16'h5555);
        n_total++;
        if (frame_done !== 1'b1) $display("FAIL b2b_fd c=%0d: got %b want 1", cyc, frame_done);
        else n_pass++;
        step();
        pulse_load(16'h7777);
        run_to(nb + 5);
        n_total++;
        if ({anodes, segments, dp_n} !== {4'b1110, 7'b0100100, 1'b0}) begin
            $display("FAIL bnd_load_d0 c=%0d: got an=%b seg=%b dpn=%b want 1110 0100100 0",
                     cyc, anodes, segments, dp_n);
        end else n_pass++;
        run_to(nb + 35);
        n_total++;
        if ({anodes, segments} !== {4'b0111, 7'b0100100}) begin
            $display("FAIL bnd_load_d3 c=%0d: got an=%b seg=%b want 0111 0100100", cyc, anodes, segments);
        end else n_pass++;
        run_to(nb + 40);
        n_total++;
        if (frame_done !== 1'b1) $display("FAIL b2b_fd2 c=%0d: got %b want 1", cyc, frame_done);
        else n_pass++;
        run_to(nb + 45);
        n_total++;
        if ({anodes, segments} !== {4'b1110, 7'b0001111}) begin
            $display("FAIL second_load_d0 c=%0d: got an=%b seg=%b want 1110 0001111", cyc, anodes, segments);
        end else n_pass++;
        run_to(nb + 55);
        n_total++;
        if ({anodes, segments} !== {4'b1101, 7'b0001111}) begin
            $display("FAIL second_load_d1 c=%0d: got an=%b seg=%b want 1101 0001111", cyc, anodes, segments);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        int nb, bad;
        digit_en = 4'b1010; dp = 4'h0; lz_blank = 1'b0;
        nb = next_bnd(cyc);
        bad = 0;
        while (cyc < nb + 15) begin
            step();
            if (anodes[0] !== 1'b1 || anodes[2] !== 1'b1 || $countones(~anodes) > 1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL disabled_digits: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_total++;
        if ({anodes, segments} !== {4'b1101, 7'b0001111}) begin
            $display("FAIL pre_reset_d1 c=%0d: got an=%b seg=%b want 1101 0001111", cyc, anodes, segments);
        end else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({anodes, segments, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            $display("FAIL async_reset: got an=%b seg=%b dpn=%b fd=%b want 1111 1111111 1 0",
                     anodes, segments, dp_n, frame_done);
        end else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (anodes !== 4'hF) $display("FAIL reset_hold: got %b want 1111", anodes);
        else n_pass++;
        release_reset();
        bad = 0;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (anodes !== 4'hF) bad++;
            n_total++;
            if (frame_done !== (cyc == 10)) begin
                $display("FAIL rerun_frame_done c=%0d: got %b want %b", cyc, frame_done, cyc == 10);
            end else n_pass++;
        end
        n_total++;
        if (bad != 0) $display("FAIL rerun_blank: got %0d lit cycles want 0", bad);
        else n_pass++;
        step();
        n_total++;
        if ({anodes, segments} !== {4'b1101, 7'b0000001}) begin
            $display("FAIL rerun_d1 c=%0d: got an=%b seg=%b want 1101 0000001", cyc, anodes, segments);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_hex_digits();
        test_midframe_load();
        test_zero_lz_dp();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
